// File: rtl/mem_ctrl_pkg.sv
// Shared opcodes, reply bytes and FSM encoding for the debug memory-access sequencer.
// Reply payloads are left-aligned in a 48-bit word and the first byte is sent first.
package mem_ctrl_pkg;

  localparam int RSP_W = 42;
  localparam int REPLY_W = 48;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_HALT  = 2'b10;
  localparam logic [1:0] OP_RUN   = 2'b11;

  localparam logic [7:0] ACK = 8'hAA;
  localparam logic [7:0] ERR = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_HALT,
    ST_REQ,
    ST_WAIT_RSP,
    ST_TX
  } state_t;

  function automatic logic [REPLY_W-1:0] single_byte(input logic [7:0] b);
    return {b, 40'h0};
  endfunction

endpackage

// File: rtl/tx_byte_serializer.sv
// Loads up to 6 left-aligned bytes and sends them MSB first over a valid/ready byte port.
// The first byte is valid the cycle after i_load; a byte is held until accepted, with no skips.
module tx_byte_serializer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [47:0] i_bytes,
  input  logic [2:0]  i_count,
  input  logic        i_tx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  output logic        o_done
);

  logic [39:0] r_rest;
  logic [2:0]  r_left;
  logic        w_accept;

  assign w_accept = o_tx_valid & i_tx_ready;
  // o_done marks the handshake of the final byte, so the owner can leave its TX state.
  assign o_done   = w_accept & (r_left == 3'd1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_tx_data  <= 8'h00;
      o_tx_valid <= 1'b0;
      r_rest     <= '0;
      r_left     <= '0;
    end else if (i_load) begin
      o_tx_data  <= i_bytes[47:40];
      r_rest     <= i_bytes[39:0];
      r_left     <= i_count;
      o_tx_valid <= (i_count != 3'd0);
    end else if (w_accept) begin
      r_left <= r_left - 3'd1;
      if (r_left == 3'd1) begin
        o_tx_valid <= 1'b0;
      end else begin
        o_tx_data <= r_rest[39:32];
        r_rest    <= {r_rest[31:0], 8'h00};
      end
    end
  end

endmodule

// File: rtl/mem_access_controller.sv
// UART command sequencer. It parses frames, halts the core, issues one memory request and replies.
// The response is expected one cycle after the request; replies stall on tx_ready and rx bytes drop while busy.
module mem_access_controller
  import mem_ctrl_pkg::*;
#(
  parameter int RSP_TIMEOUT  = 15,
  parameter int BYTE_TIMEOUT = 50000,
  parameter bit RUN_ON_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             enable,
  output logic             write_mem_req,
  output logic             target_mem_type,
  output logic [8:0]       target_addr,
  output logic             rw_flag,
  output logic [31:0]      wdata,
  input  logic [RSP_W-1:0] instr_rsp,
  input  logic             instr_rdy,
  input  logic [RSP_W-1:0] data_rsp,
  input  logic             data_rdy,
  output logic             busy,
  output logic             rx_drop
);

  localparam int RT_W = $clog2(RSP_TIMEOUT + 1);
  localparam int BT_W = $clog2(BYTE_TIMEOUT + 1);

  state_t             r_state;
  logic               r_run_state;
  logic               r_addr_hi;
  logic [1:0]         r_byte_cnt;
  logic [BT_W-1:0]    r_byte_tmr;
  logic [RT_W-1:0]    r_rsp_tmr;
  logic               r_ld;
  logic [REPLY_W-1:0] r_ld_bytes;
  logic [2:0]         r_ld_cnt;

  logic               w_done;
  logic               w_sel_rdy;
  logic [RSP_W-1:0]   w_sel_rsp;
  logic [1:0]         w_op;
  logic               w_drop_state;

  assign w_op         = rx_data[7:6];
  // Only the addressed memory may complete a read; the other strobe is ignored.
  assign w_sel_rdy    = target_mem_type ? instr_rdy : data_rdy;
  assign w_sel_rsp    = target_mem_type ? instr_rsp : data_rsp;
  assign w_drop_state = (r_state == ST_HALT) || (r_state == ST_REQ) ||
                        (r_state == ST_WAIT_RSP) || (r_state == ST_TX);
  assign busy         = (r_state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_run_state     <= RUN_ON_RESET;
      enable          <= RUN_ON_RESET;
      write_mem_req   <= 1'b0;
      target_mem_type <= 1'b0;
      target_addr     <= '0;
      rw_flag         <= 1'b0;
      wdata           <= '0;
      rx_drop         <= 1'b0;
      r_addr_hi       <= 1'b0;
      r_byte_cnt      <= '0;
      r_byte_tmr      <= '0;
      r_rsp_tmr       <= '0;
      r_ld            <= 1'b0;
      r_ld_bytes      <= '0;
      r_ld_cnt        <= '0;
    end else begin
      r_ld          <= 1'b0;
      write_mem_req <= 1'b0;
      rx_drop       <= rx_valid & w_drop_state;

      case (r_state)
        ST_IDLE: begin
          if (rx_valid) begin
            case (w_op)
              OP_HALT: begin
                r_run_state <= 1'b0;
                enable      <= 1'b0;
                r_ld_bytes  <= single_byte(ACK);
                r_ld_cnt    <= 3'd1;
                r_ld        <= 1'b1;
                r_state     <= ST_TX;
              end
              OP_RUN: begin
                r_run_state <= 1'b1;
                enable      <= 1'b1;
                r_ld_bytes  <= single_byte(ACK);
                r_ld_cnt    <= 3'd1;
                r_ld        <= 1'b1;
                r_state     <= ST_TX;
              end
              default: begin
                rw_flag         <= (w_op == OP_WRITE);
                target_mem_type <= rx_data[5];
                r_addr_hi       <= rx_data[0];
                r_byte_tmr      <= '0;
                r_state         <= ST_ADDR;
              end
            endcase
          end
        end

        ST_ADDR: begin
          if (rx_valid) begin
            r_byte_tmr  <= '0;
            target_addr <= {r_addr_hi, rx_data};
            if (rw_flag) begin
              r_byte_cnt <= '0;
              r_state    <= ST_DATA;
            end else begin
              enable  <= 1'b0;
              r_state <= ST_HALT;
            end
          end else if (r_byte_tmr == BT_W'(BYTE_TIMEOUT - 1)) begin
            r_state <= ST_IDLE;
          end else begin
            r_byte_tmr <= r_byte_tmr + 1'b1;
          end
        end

        ST_DATA: begin
          if (rx_valid) begin
            r_byte_tmr <= '0;
            wdata      <= {wdata[23:0], rx_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              enable  <= 1'b0;
              r_state <= ST_HALT;
            end
          end else if (r_byte_tmr == BT_W'(BYTE_TIMEOUT - 1)) begin
            r_state <= ST_IDLE;
          end else begin
            r_byte_tmr <= r_byte_tmr + 1'b1;
          end
        end

        // enable is already low here, so the memory honours the request issued next cycle.
        ST_HALT: begin
          write_mem_req <= 1'b1;
          r_state       <= ST_REQ;
        end

        ST_REQ: begin
          if (rw_flag) begin
            r_ld_bytes <= single_byte(ACK);
            r_ld_cnt   <= 3'd1;
            r_ld       <= 1'b1;
            r_state    <= ST_TX;
          end else begin
            r_rsp_tmr <= '0;
            r_state   <= ST_WAIT_RSP;
          end
        end

        ST_WAIT_RSP: begin
          if (w_sel_rdy) begin
            r_ld_bytes <= {6'b0, w_sel_rsp};
            r_ld_cnt   <= 3'd6;
            r_ld       <= 1'b1;
            r_state    <= ST_TX;
          end else if (r_rsp_tmr == RT_W'(RSP_TIMEOUT - 1)) begin
            r_ld_bytes <= single_byte(ERR);
            r_ld_cnt   <= 3'd1;
            r_ld       <= 1'b1;
            r_state    <= ST_TX;
          end else begin
            r_rsp_tmr <= r_rsp_tmr + 1'b1;
          end
        end

        ST_TX: begin
          if (w_done) begin
            enable  <= r_run_state;
            r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  tx_byte_serializer u_tx (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_load     (r_ld),
    .i_bytes    (r_ld_bytes),
    .i_count    (r_ld_cnt),
    .i_tx_ready (tx_ready),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .o_done     (w_done)
  );

endmodule

// File: doc/mem_access_controller.md
Name: mem_access_controller

Overview:
- UART-side command sequencer for the CPU's debug/programming path to instruction and data memory.
- Parses a byte-stream command frame and halts the core (enable low) before any access.
- Issues a one-cycle memory request, collects the 42-bit read response from the selected memory and serializes the reply to the UART TX byte interface.
- Also executes explicit halt/run commands. Sits between the UART RX/TX byte engines and the memories' write_mem_req port group.

Parameters:
- RSP_TIMEOUT, 15, cycles to wait for a read-ready pulse after the request before reporting an error.
- BYTE_TIMEOUT, 50000, idle cycles allowed between bytes of one frame before the frame is abandoned.
- RUN_ON_RESET, 1, reset value of enable (1 = core runs after reset).

Ports:
- clk  in  1  system clock
- reset  in  1  async active-high reset
- rx_data  in  8  received UART byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid; held until tx_ready
- tx_ready  in  1  TX engine accepts byte when tx_valid&tx_ready
- enable  out  1  core run enable; memory access permitted only while low
- write_mem_req  out  1  one-cycle memory access request
- target_mem_type  out  1  1 = instruction memory, 0 = data memory
- target_addr  out  9  word address
- rw_flag  out  1  1 = write, 0 = read
- wdata  out  32  write data (memory uart_rx_data_in)
- instr_rsp  in  42  instruction memory read response {1'b1, addr, data}
- instr_rdy  in  1  instruction memory response strobe
- data_rsp  in  42  data memory read response
- data_rdy  in  1  data memory response strobe
- busy  out  1  high in any state other than IDLE
- rx_drop  out  1  one-cycle pulse when a byte arrives while not accepting

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-high, named reset.
- Reset values:
  - enable=RUN_ON_RESET, run_state=RUN_ON_RESET.
  - write_mem_req=0, target_mem_type=0, target_addr=0, rw_flag=0, wdata=0.
  - tx_valid=0, tx_data=0, busy=0, rx_drop=0; FSM=IDLE.
- Command byte fields:
  - [7:6] opcode: 00 read, 01 write, 10 halt, 11 run.
  - [5] target_mem_type.
  - [0] addr[8].
  - [4:1] ignored.
- Frames:
  - read = cmd, addr_lo.
  - write = cmd, addr_lo, 4 data bytes MSB first.
  - halt/run = cmd only.
- FSM states: IDLE, ADDR, DATA, HALT, REQ, WAIT_RSP, TX.
- IDLE:
  - On rx_valid, latch cmd.
  - halt: run_state=0, enable=0, queue ack 0xAA, go to TX.
  - run: run_state=1, enable=1, queue ack 0xAA, go to TX.
  - read/write: go to ADDR.
- ADDR: on byte, target_addr={cmd[0],byte}. Read goes to HALT; write goes to DATA with byte counter=0.
- DATA: shift bytes into wdata; after the 4th byte go to HALT.
- HALT: drive enable=0 for exactly this cycle before the request (a memory ignores requests while enable=1); go to REQ.
- REQ:
  - write_mem_req=1 for exactly one cycle, with rw_flag, target_mem_type, target_addr, wdata stable this cycle.
  - Write: queue ack 0xAA and go to TX.
  - Read: clear the timeout counter and go to WAIT_RSP.
- WAIT_RSP:
  - Sample the ready of the selected target only; the other memory's ready is ignored.
  - On ready, capture rsp into a 48-bit reply {6'b0, rsp} and queue 6 bytes MSB first.
  - If the counter reaches RSP_TIMEOUT, queue the single byte 0xEE.
  - Expected latency: ready at REQ+1.
- TX:
  - Present the queued bytes one at a time; advance only on tx_valid&tx_ready; tx_valid deasserts after the last byte.
  - Then enable=run_state and go to IDLE.
  - enable remains 0 throughout REQ..TX for memory ops.
- Byte timeout: in ADDR/DATA, a counter resets on each rx_valid. Reaching BYTE_TIMEOUT abandons the frame, returns to IDLE with no reply, and leaves enable=run_state.
- rx_valid in HALT/REQ/WAIT_RSP/TX: byte discarded, rx_drop pulses.
- Reset mid-operation: all outputs return to reset values immediately; partial frames and replies are lost.

Decomposition:
- Shared package (mem_ctrl_pkg):
  - opcode constants: OP_READ, OP_WRITE, OP_HALT, OP_RUN.
  - reply bytes: ACK=8'hAA, ERR=8'hEE.
  - FSM state encoding; RSP_W=42.
- Sub-module: tx_byte_serializer. Loads up to 6 bytes plus a count and runs the tx_valid/tx_ready handshake; it is shared by the ack, error and read replies.

Test Plan:
- Frame 0x40,0x05,0xDE,0xAD,0xBE,0xEF on an idle running core:
  - enable falls before write_mem_req.
  - One-cycle req with rw_flag=1, target_mem_type=0, target_addr=0x005, wdata=0xDEADBEEF.
  - TX 0xAA, then enable returns to 1.
- Frame 0x21,0x10 with instr_rdy pulse one cycle after req, instr_rsp={1,9'h110,32'h00000013}:
  - req has rw_flag=0, target_mem_type=1, addr=0x110.
  - TX bytes 0x03,0x10,0x00,0x00,0x00,0x13.
- Read with no ready asserted: after RSP_TIMEOUT cycles, TX single 0xEE; a data_rdy pulse during an instr read is ignored.
- Halt frame 0x80, then a write, then run 0xC0:
  - enable stays 0 after the write's ack.
  - enable goes 1 only after the run ack.
- Stalls and drops:
  - tx_ready held low 20 cycles mid-reply: tx_data/tx_valid stable, no byte skipped.
  - An rx byte injected during TX gives an rx_drop pulse and the reply is unchanged.
- Timeout and reset:
  - Partial write frame (cmd+addr only) idle for BYTE_TIMEOUT: no req, no TX, FSM IDLE.
  - reset asserted in WAIT_RSP: all outputs at reset values asynchronously.
